// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared opcode and FSM state definitions for poly_horner
package poly_pkg;

   localparam logic [3:0] OP_X = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      HOLD
   } state_t;

endpackage

// File: rtl/poly_fxmul.sv
// rtl/poly_fxmul.sv - combinational signed fixed-point multiply
// Sign-magnitude product truncated toward zero, then wrapped or clamped to W bits.
module poly_fxmul #(
   parameter int W    = 32,
   parameter int FRAC = 16,
   parameter int SAT  = 0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   localparam logic [W-1:0]   MAXPOS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]   MAXNEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [2*W-1:0] HALF   = (2*W)'(1) << (W-1);

   logic [W-1:0]   ma, mb;
   logic [2*W-1:0] p, q;
   logic           neg;

   always_comb begin
      neg = a[W-1] ^ b[W-1];
      // the most negative input negates to itself, which read as unsigned is its magnitude
      ma  = a[W-1] ? -a : a;
      mb  = b[W-1] ? -b : b;
      p   = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
      q   = p >> FRAC;
      y   = neg ? -q[W-1:0] : q[W-1:0];
      if (SAT != 0) begin
         if (neg && q > HALF)
            y = MAXNEG;
         else if (!neg && q >= HALF)
            y = MAXPOS;
      end
   end

endmodule

// File: rtl/poly_horner.sv
// rtl/poly_horner.sv - sequential Horner polynomial evaluator
// One multiply-add step per clock on a shared multiplier; result held until stopout drops.
module poly_horner
   import poly_pkg::*;
#(
   parameter int W     = 32,
   parameter int FRAC  = 16,
   parameter int ORDER = 5,
   parameter int SAT   = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pushin,
   input  logic [3:0]   opin,
   input  logic [W-1:0] datain,
   output logic         readyin,
   output logic         pushout,
   output logic [W-1:0] dataout,
   input  logic         stopout
);

   localparam int           CW     = $clog2(ORDER + 1);
   localparam logic [W-1:0] ONE    = W'(1) << FRAC;
   localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MAXNEG = {1'b1, {(W-1){1'b0}}};

   state_t          state;
   logic [W-1:0]    coef [0:ORDER];
   logic [W-1:0]    x, acc;
   logic [CW-1:0]   cnt;

   logic [W-1:0]    prod, cur, sum;
   logic [W:0]      sum_w;
   logic            accept, do_start, do_write;

   poly_fxmul #(.W(W), .FRAC(FRAC), .SAT(SAT)) u_mul (
      .a (acc),
      .b (x),
      .y (prod)
   );

   assign readyin  = (state == IDLE) | ((state == HOLD) & !stopout);
   assign accept   = pushin & readyin;
   assign do_start = accept & (opin == OP_X);
   assign do_write = accept & (opin <= 4'(ORDER));

   always_comb begin
      cur   = coef[cnt];
      sum_w = {prod[W-1], prod} + {cur[W-1], cur};
      sum   = sum_w[W-1:0];
      if (SAT != 0 && sum_w[W] != sum_w[W-1])
         sum = sum_w[W] ? MAXNEG : MAXPOS;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= ORDER; k++)
            coef[k] <= ONE;
         x       <= '0;
         acc     <= '0;
         cnt     <= '0;
         state   <= IDLE;
         pushout <= 1'b0;
         dataout <= '0;
      end else begin
         case (state)
            CALC: begin
               acc <= sum;
               if (cnt == '0) begin
                  state   <= HOLD;
                  pushout <= 1'b1;
                  dataout <= sum;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (!stopout) begin
                  state   <= IDLE;
                  pushout <= 1'b0;
               end
            end
            default: ;
         endcase
         // accepted loads apply equally from IDLE and from a released HOLD
         if (do_write)
            coef[opin[CW-1:0]] <= datain;
         if (do_start) begin
            x     <= datain;
            acc   <= coef[ORDER];
            cnt   <= CW'(ORDER - 1);
            state <= CALC;
         end
      end
   end

endmodule

// File: tb/tb_poly_horner.sv
// tb/tb_poly_horner.sv - self-checking bench for poly_horner
// Wrap and saturate instances share stimulus; a narrow ORDER=2 instance covers the small config.
module tb_poly_horner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        pushin = 1'b0, stopout = 1'b0;
   logic [3:0]  opin = '0;
   logic [31:0] datain = '0;
   logic        ready0, push0, ready1, push1;
   logic [31:0] dout0, dout1;

   logic        p2 = 1'b0, s2 = 1'b0;
   logic [3:0]  op2 = '0;
   logic [15:0] d2 = '0;
   logic        r2, po2;
   logic [15:0] do2;

   poly_horner #(.W(32), .FRAC(16), .ORDER(5), .SAT(0)) dut0 (
      .clk(clk), .rst(rst), .pushin(pushin), .opin(opin), .datain(datain),
      .readyin(ready0), .pushout(push0), .dataout(dout0), .stopout(stopout));

   poly_horner #(.W(32), .FRAC(16), .ORDER(5), .SAT(1)) dut1 (
      .clk(clk), .rst(rst), .pushin(pushin), .opin(opin), .datain(datain),
      .readyin(ready1), .pushout(push1), .dataout(dout1), .stopout(stopout));

   poly_horner #(.W(16), .FRAC(8), .ORDER(2), .SAT(0)) dut2 (
      .clk(clk), .rst(rst), .pushin(p2), .opin(op2), .datain(d2),
      .readyin(r2), .pushout(po2), .dataout(do2), .stopout(s2));

   int     checks = 0;
   int     errors = 0;
   longint mcoef [0:5];

   typedef struct {
      logic [31:0] a5;
      logic [31:0] x;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vec [0:4];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic longint sx(input longint v, input int w);
      logic [63:0] u;
      u = 64'(v) << (64 - w);
      return longint'($signed(u) >>> (64 - w));
   endfunction

   function automatic longint fit(input longint v, input int w, input bit sat);
      longint lim;
      lim = longint'(1) << (w - 1);
      if (!sat) return sx(v, w);
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
   endfunction

   function automatic longint fmul(input longint a, input longint b, input bit sat);
      longint unsigned ma, mb, q;
      ma = (a < 0) ? longint'(-a) : a;
      mb = (b < 0) ? longint'(-b) : b;
      q  = (ma * mb) >> 16;
      return fit(((a < 0) != (b < 0)) ? -longint'(q) : longint'(q), 32, sat);
   endfunction

   function automatic longint horner(input longint xv, input bit sat);
      longint acc;
      acc = mcoef[5];
      for (int k = 4; k >= 0; k--)
         acc = fit(fmul(acc, xv, sat) + mcoef[k], 32, sat);
      return acc;
   endfunction

   function automatic logic [31:0] rv();
      logic [31:0] v;
      case ($urandom_range(0, 2))
         0: v = $urandom;
         1: v = 32'($urandom_range(0, (1 << 19) - 1)) - 32'(1 << 18);
         default: begin
            case ($urandom_range(0, 3))
               0: v = 32'h8000_0000;
               1: v = 32'h7FFF_FFFF;
               2: v = 32'h0001_0000;
               default: v = 32'hFFFF_0000;
            endcase
         end
      endcase
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k <= 5; k++) mcoef[k] = 64'h1_0000;
   endtask

   task automatic write_coef(input int k, input logic [31:0] v);
      pushin = 1'b1;
      opin   = 4'(k);
      datain = v;
      @(negedge clk);
      pushin = 1'b0;
      if (k <= 5) mcoef[k] = sx(longint'(v), 32);
   endtask

   // Waits for the result following an op15 push accepted at the coming edge.
   task automatic wait_result(output logic [31:0] r0, output logic [31:0] r1);
      int n;
      @(negedge clk);
      pushin = 1'b0;
      n = 1;
      while (!push0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, 6);
      check("push1", longint'(push1), 1);
      r0 = dout0;
      r1 = dout1;
   endtask

   task automatic run_eval(input logic [31:0] xv, input int stall,
                           output logic [31:0] r0, output logic [31:0] r1);
      pushin = 1'b1;
      opin   = 4'd15;
      datain = xv;
      wait_result(r0, r1);
      if (stall > 0) begin
         stopout = 1'b1;
         repeat (stall) @(negedge clk);
         check("stall_hold", longint'({push0, dout0}), longint'({1'b1, r0}));
         stopout = 1'b0;
      end
      @(negedge clk);
      check("single_pulse", longint'(push0), 0);
   endtask

   initial begin
      logic [31:0] r0, r1;
      longint      m0, m1;
      int          n;
      bit          seen;

      vec[0] = '{32'h0001_0000, 32'h0001_0000, 32'h0006_0000, 32'h0006_0000};
      vec[1] = '{32'h0001_0000, 32'h0002_0000, 32'h003F_0000, 32'h003F_0000};
      vec[2] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000};
      vec[3] = '{32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 32'h0001_0000};
      vec[4] = '{32'h7FFF_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h7FFF_FFFF};

      do_reset();
      check("rst_pushout", longint'({push0, push1, po2}), 0);
      check("rst_dataout", longint'({dout0, dout1, do2}), 0);
      check("rst_readyin", longint'({ready0, ready1, r2}), 7);

      for (int i = 0; i < 5; i++) begin
         write_coef(5, vec[i].a5);
         run_eval(vec[i].x, 0, r0, r1);
         check($sformatf("vec%0d_wrap", i), longint'(r0), longint'(vec[i].e0));
         check($sformatf("vec%0d_sat", i), longint'(r1), longint'(vec[i].e1));
      end

      // stall in HOLD with an ignored coefficient write, then release with a new start
      do_reset();
      pushin = 1'b1; opin = 4'd15; datain = 32'h0001_0000;
      wait_result(r0, r1);
      check("hold_first", longint'(r0), 32'h0006_0000);
      stopout = 1'b1;
      pushin = 1'b1; opin = 4'd0; datain = 32'h0005_0000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("hold_stable%0d", c), longint'({push0, ready0, dout0}),
               longint'({1'b1, 1'b0, 32'h0006_0000}));
      end
      stopout = 1'b0; opin = 4'd15; datain = 32'h0002_0000;
      #1;
      check("hold_release_ready", longint'(ready0), 1);
      wait_result(r0, r1);
      check("hold_b2b", longint'(r0), 32'h003F_0000);
      @(negedge clk);

      // reset during the third CALC cycle discards the evaluation and restores coefficients
      write_coef(0, 32'h0003_0000);
      pushin = 1'b1; opin = 4'd15; datain = 32'h0001_0000;
      @(negedge clk);
      pushin = 1'b0;
      check("calc_not_ready", longint'(ready0), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k <= 5; k++) mcoef[k] = 64'h1_0000;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (push0) seen = 1'b1;
      end
      check("rst_mid_calc_no_push", longint'(seen), 0);
      run_eval(32'h0001_0000, 0, r0, r1);
      check("rst_mid_calc_coef", longint'(r0), 32'h0006_0000);

      // randomized coefficient/argument traffic against the arithmetic model
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(0, 3)) write_coef($urandom_range(0, 14), rv());
         datain = rv();
         m0 = horner(sx(longint'(datain), 32), 1'b0);
         m1 = horner(sx(longint'(datain), 32), 1'b1);
         run_eval(datain, $urandom_range(0, 2), r0, r1);
         check($sformatf("rand%0d_wrap", it), longint'(r0), longint'({32'b0, m0[31:0]}));
         check($sformatf("rand%0d_sat", it), longint'(r1), longint'({32'b0, m1[31:0]}));
      end

      // narrow ORDER=2 instance
      for (int k = 0; k < 3; k++) begin
         p2 = 1'b1; op2 = 4'(k); d2 = 16'(16'h0100 * (k + 1));
         @(negedge clk);
      end
      op2 = 4'd15; d2 = 16'h0200;
      @(negedge clk);
      p2 = 1'b0;
      n = 1;
      while (!po2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("o2_latency", n, 3);
      check("o2_result", longint'(do2), 16'h1100);
      @(negedge clk);
      check("o2_single_pulse", longint'(po2), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
